// File: rtl/wb_pkg.sv
// Shared Wishbone types: arbiter state encoding and the master request bundle.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;
  localparam int unsigned OUTST_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_outst_cnt.sv
// Up/down counter of strobes accepted by the slave but not yet acknowledged.
module wb_outst_cnt
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  output logic [OUTST_W-1:0] count
);

  // Simultaneous accept and ack leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + OUTST_W'(1);
    end else if (dec && !inc) begin
      count <= count - OUTST_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone B4 pipelined arbiter in front of one slave.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_stall_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_stall_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_stall_i,
  output logic [1:0]              grant_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
  } req_t;

  arb_state_e         state, state_next;
  logic               last, last_next;
  logic [OUTST_W-1:0] outst;
  req_t               m0_req, m1_req, own_req;
  logic               owned, outst_nz, ack_v, full;

  assign m0_req   = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                      sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
  assign m1_req   = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                      sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};
  assign own_req  = (state == GNT1) ? m1_req : m0_req;
  assign owned    = (state != IDLE);
  assign outst_nz = (outst != '0);
  // Acks with nothing outstanding are strays and are dropped.
  assign ack_v    = s_ack_i & outst_nz;
  assign full     = (outst == OUTST_W'(MAX_OUTST)) & ~ack_v;
  assign grant_o  = {state == GNT1, state == GNT0};

  wb_outst_cnt u_outst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_next != state),
    .inc   (s_stb_o & ~s_stall_i),
    .dec   (ack_v),
    .count (outst)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_dat_o   = '0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_dat_o   = '0;
    m1_stall_o = 1'b1;

    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: if (!m0_cyc_i && !outst_nz) state_next = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i && !outst_nz) state_next = m0_cyc_i ? GNT0 : IDLE;
      default: state_next = IDLE;
    endcase

    if (state_next != state && state_next != IDLE) last_next = (state_next == GNT1);

    // Slave cycle stays open while acks are still owed to a master that left.
    if (owned) begin
      s_cyc_o = own_req.cyc | outst_nz;
      s_stb_o = own_req.stb & ~full;
      s_we_o  = own_req.we;
      s_sel_o = own_req.sel;
      s_adr_o = own_req.adr;
      s_dat_o = own_req.dat;
    end

    if (state == GNT0) begin
      m0_ack_o   = ack_v;
      m0_dat_o   = s_dat_i;
      m0_stall_o = s_stall_i | full;
    end
    if (state == GNT1) begin
      m1_ack_o   = ack_v;
      m1_dat_o   = s_dat_i;
      m1_stall_o = s_stall_i | full;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with MAX_OUTST = 4.
module tb_wb_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_stall_i;
  logic [1:0]    grant_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_stall_o(m0_stall_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_stall_i(s_stall_i), .grant_o(grant_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = '1; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = '1; m1_adr_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_stall_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant_o); end
    n_cmp++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_slave: cyc %b stb %b want 0 0", s_cyc_o, s_stb_o); end
    n_cmp++; if (m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_stall: %b %b want 1 1", m0_stall_o, m1_stall_o); end
    n_cmp++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack: %b %b want 0 0", m0_ack_o, m1_ack_o); end
  endtask

  task automatic test_single_master();
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h8000_0000;
    #1;
    n_cmp++; if (grant_o !== 2'b00 || m0_stall_o !== 1'b1 || s_stb_o !== 1'b0) begin n_bad++; $display("FAIL sm_idle: grant %b stall %b stb %b want 00 1 0", grant_o, m0_stall_o, s_stb_o); end
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL sm_grant: got %b want 01", grant_o); end
    n_cmp++; if (s_stb_o !== 1'b1 || s_adr_o !== 32'h8000_0000 || m0_stall_o !== 1'b0) begin n_bad++; $display("FAIL sm_first_stb: stb %b adr %h stall %b want 1 80000000 0", s_stb_o, s_adr_o, m0_stall_o); end
    n_cmp++; if (m1_stall_o !== 1'b1 || m1_ack_o !== 1'b0) begin n_bad++; $display("FAIL sm_nonowner: stall %b ack %b want 1 0", m1_stall_o, m1_ack_o); end
    tick();
    m0_adr_i = 32'h8000_0004; s_ack_i = 1'b1; s_dat_i = 32'hA0A0_0000;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hA0A0_0000 || s_adr_o !== 32'h8000_0004) begin n_bad++; $display("FAIL sm_ack0: ack %b dat %h adr %h want 1 a0a00000 80000004", m0_ack_o, m0_dat_o, s_adr_o); end
    n_cmp++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin n_bad++; $display("FAIL sm_m1_quiet: ack %b dat %h want 0 0", m1_ack_o, m1_dat_o); end
    tick();
    m0_adr_i = 32'h8000_0008; s_dat_i = 32'hA1A1_0004;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hA1A1_0004 || s_stb_o !== 1'b1) begin n_bad++; $display("FAIL sm_ack1: ack %b dat %h stb %b want 1 a1a10004 1", m0_ack_o, m0_dat_o, s_stb_o); end
    tick();
    m0_stb_i = 1'b0; s_dat_i = 32'hA2A2_0008;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hA2A2_0008 || s_stb_o !== 1'b0) begin n_bad++; $display("FAIL sm_ack2: ack %b dat %h stb %b want 1 a2a20008 0", m0_ack_o, m0_dat_o, s_stb_o); end
    tick();
    m0_cyc_i = 1'b0; s_ack_i = 1'b0;
    #1;
    n_cmp++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin n_bad++; $display("FAIL sm_drop: cyc %b grant %b want 0 01", s_cyc_o, grant_o); end
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL sm_release: got %b want 00", grant_o); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    n_cmp++; if (grant_o !== 2'b01 || m1_stall_o !== 1'b1) begin n_bad++; $display("FAIL tie_first: grant %b m1_stall %b want 01 1", grant_o, m1_stall_o); end
    m0_cyc_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL tie_handover: got %b want 10", grant_o); end
    m0_cyc_i = 1'b1;
    tick();
    n_cmp++; if (grant_o !== 2'b10 || m0_stall_o !== 1'b1) begin n_bad++; $display("FAIL tie_hold: grant %b m0_stall %b want 10 1", grant_o, m0_stall_o); end
    m1_cyc_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL tie_back: got %b want 01", grant_o); end
    m0_cyc_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL tie_idle: got %b want 00", grant_o); end
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL tie_rr: got %b want 10", grant_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_full();
    int acc;
    int acks;
    acc = 0;
    acks = 0;
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      m1_adr_i = AW'(acc * 4);
      #1;
      n_cmp++; if (m1_stall_o !== (c >= 4) || s_stb_o !== (c < 4)) begin n_bad++; $display("FAIL full_cyc%0d: stall %b stb %b want %b %b", c, m1_stall_o, s_stb_o, c >= 4, c < 4); end
      if (!m1_stall_o) acc++;
      tick();
    end
    n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL full_accepted: got %0d want 4", acc); end
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m1_ack_o !== 1'b1 || m1_stall_o !== 1'b0 || s_stb_o !== 1'b1) begin n_bad++; $display("FAIL full_relief: ack %b stall %b stb %b want 1 0 1", m1_ack_o, m1_stall_o, s_stb_o); end
    acks++;
    tick();
    s_ack_i = 1'b0;
    #1;
    n_cmp++; if (m1_stall_o !== 1'b1 || s_stb_o !== 1'b0) begin n_bad++; $display("FAIL full_again: stall %b stb %b want 1 0", m1_stall_o, s_stb_o); end
    tick();
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m1_stall_o !== 1'b0) begin n_bad++; $display("FAIL full_sixth: stall %b want 0", m1_stall_o); end
    acks++;
    tick();
    m1_stb_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (m1_ack_o !== 1'b1 || s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL full_drain%0d: ack %b cyc %b want 1 1", k, m1_ack_o, s_cyc_o); end
      acks++;
      tick();
    end
    s_ack_i = 1'b0; m1_cyc_i = 1'b0;
    #1;
    n_cmp++; if (acks != 6 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL full_done: acks %0d cyc %b want 6 0", acks, s_cyc_o); end
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL full_idle: got %b want 00", grant_o); end
  endtask

  task automatic test_early_drop();
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    tick();
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b1;
    #1;
    n_cmp++; if (s_cyc_o !== 1'b1 || grant_o !== 2'b01 || m1_stall_o !== 1'b1 || s_stb_o !== 1'b0) begin n_bad++; $display("FAIL ed_hold: cyc %b grant %b m1_stall %b stb %b want 1 01 1 0", s_cyc_o, grant_o, m1_stall_o, s_stb_o); end
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hB0B0_B0B0;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hB0B0_B0B0 || s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL ed_ack0: ack %b dat %h cyc %b want 1 b0b0b0b0 1", m0_ack_o, m0_dat_o, s_cyc_o); end
    tick();
    s_dat_i = 32'hB1B1_B1B1;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b1 || grant_o !== 2'b01 || s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL ed_ack1: ack %b grant %b cyc %b want 1 01 1", m0_ack_o, grant_o, s_cyc_o); end
    tick();
    s_ack_i = 1'b0;
    #1;
    n_cmp++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin n_bad++; $display("FAIL ed_closed: cyc %b grant %b want 0 01", s_cyc_o, grant_o); end
    tick();
    n_cmp++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL ed_m1: grant %b cyc %b want 10 1", grant_o, s_cyc_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_stray_ack();
    do_reset();
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL stray_idle: acks %b %b cyc %b want 0 0 0", m0_ack_o, m1_ack_o, s_cyc_o); end
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b1;
    tick();
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m0_ack_o !== 1'b0 || grant_o !== 2'b01) begin n_bad++; $display("FAIL stray_gnt: ack %b grant %b want 0 01", m0_ack_o, grant_o); end
    m0_cyc_i = 1'b0;
    tick();
    s_ack_i = 1'b0;
    #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL stray_no_underflow: grant %b want 00", grant_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    tick();
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rm_state: grant %b cyc %b want 00 0", grant_o, s_cyc_o); end
    n_cmp++; if (m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1) begin n_bad++; $display("FAIL rm_stall: %b %b want 1 1", m0_stall_o, m1_stall_o); end
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL rm_late_ack0: %b %b want 0 0", m0_ack_o, m1_ack_o); end
    tick();
    n_cmp++; if (m1_ack_o !== 1'b0 || grant_o !== 2'b00) begin n_bad++; $display("FAIL rm_late_ack1: ack %b grant %b want 0 00", m1_ack_o, grant_o); end
    s_ack_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_master();
    test_tie();
    test_full();
    test_early_drop();
    test_stray_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
